// File: rtl/rs_pipeline_pkg.sv
// ----------------------------------------------------------------------------
// rs_pipeline_pkg
// Shared constants and helpers for the relay-station credit controller.
//   DATA_WIDTH : default payload width in bits
//   PIPE_LEVEL : default forward latency of the external relay-station pipeline
//   DEPTH      : default tail FIFO depth, which is also the initial credit count
//   clog2()    : ceil(log2(value)), used to size counters and pointers
// ----------------------------------------------------------------------------
package rs_pipeline_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int PIPE_LEVEL = 4;
    localparam int DEPTH      = 8;

    // Number of bits needed to index 'value' distinct items (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rs_credit_fifo.sv
// ----------------------------------------------------------------------------
// rs_credit_fifo
// First-word-fall-through tail FIFO that absorbs everything the relay-station
// pipeline delivers. The credit scheme upstream guarantees room, so a write
// into a full FIFO is a system fault: the word is dropped and a sticky
// overflow flag is raised.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   wr_valid      : tail word valid (written every cycle it is high)
//   wr_data       : tail word
//   rd_en         : consumer read strobe (ignored while empty)
//   rd_data       : word at the read pointer, valid while empty_n is high
//   empty_n       : registered "FIFO holds at least one word"
//   overflow_err  : sticky, set when a write hits a full FIFO
// ----------------------------------------------------------------------------
module rs_credit_fifo
    import rs_pipeline_pkg::clog2;
#(
    parameter int DATA_WIDTH = rs_pipeline_pkg::DATA_WIDTH,
    parameter int DEPTH      = rs_pipeline_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty_n,
    output logic                  overflow_err
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  full;
    logic                  do_read;
    logic                  do_write;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full     = (count == DEPTH_CNT);
    assign do_read  = rd_en & empty_n;
    // A full FIFO drops the incoming word even if a read frees a slot in the
    // same cycle; reaching this point already means credits were violated.
    assign do_write = wr_valid & ~full;

    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = count;
        unique case ({do_write, do_read})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            empty_n      <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (do_read) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_write) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            count   <= count_next;
            empty_n <= (count_next != '0);
            if (wr_valid && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; empty_n guards stale contents.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rs_pipeline_credit_ctrl.sv
// ----------------------------------------------------------------------------
// rs_pipeline_credit_ctrl
// Credit-based flow control around an external relay-station FF pipeline.
// The producer may only launch a word while a credit is available; each word
// launched consumes a credit and each word the consumer reads from the tail
// FIFO returns one, so the FIFO can never be overrun in a correct system.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   if_din         : producer payload
//   if_write       : producer write strobe
//   if_full_n      : high when at least one credit is available
//   pp_head_din    : registered payload to the pipeline head
//   pp_head_valid  : registered accepted write to the pipeline head
//   pp_tail_dout   : payload from the pipeline tail
//   pp_tail_valid  : valid from the pipeline tail
//   if_dout        : FIFO head word, valid while if_empty_n is high
//   if_empty_n     : FIFO holds at least one word
//   if_read        : consumer read strobe
//   idle           : all credits home (nothing in flight or buffered)
//   overflow_err   : sticky tail FIFO overflow flag
// ----------------------------------------------------------------------------
module rs_pipeline_credit_ctrl
    import rs_pipeline_pkg::clog2;
#(
    parameter int DATA_WIDTH = rs_pipeline_pkg::DATA_WIDTH,
    parameter int PIPE_LEVEL = rs_pipeline_pkg::PIPE_LEVEL,
    parameter int DEPTH      = rs_pipeline_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] pp_head_din,
    output logic                  pp_head_valid,
    input  logic [DATA_WIDTH-1:0] pp_tail_dout,
    input  logic                  pp_tail_valid,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic                  idle,
    output logic                  overflow_err
);

    // The FIFO must cover at least the words that can be in flight.
    if (DEPTH < PIPE_LEVEL + 1 || DEPTH > 256) begin : g_bad_depth
        $error("rs_pipeline_credit_ctrl: DEPTH must be in PIPE_LEVEL+1 .. 256");
    end

    localparam int CRED_W = clog2(DEPTH + 1);
    localparam logic [CRED_W-1:0] FULL_CREDITS = CRED_W'(DEPTH);

    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] credits_next;
    logic              accept_write;
    logic              accept_read;

    assign accept_write = if_write & if_full_n;
    assign accept_read  = if_read & if_empty_n;

    // Writes are gated by if_full_n, so credits cannot drop below zero; reads
    // only return credits that a write consumed, so they cannot exceed DEPTH.
    always_comb begin
        credits_next = credits;
        unique case ({accept_write, accept_read})
            2'b10:   credits_next = credits - CRED_W'(1);
            2'b01:   credits_next = credits + CRED_W'(1);
            default: credits_next = credits;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits       <= FULL_CREDITS;
            if_full_n     <= 1'b1;
            idle          <= 1'b1;
            pp_head_valid <= 1'b0;
            pp_head_din   <= '0;
        end else begin
            credits       <= credits_next;
            if_full_n     <= (credits_next != '0);
            idle          <= (credits_next == FULL_CREDITS);
            pp_head_valid <= accept_write;
            pp_head_din   <= if_din;
        end
    end

    rs_credit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_tail_fifo (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (pp_tail_valid),
        .wr_data      (pp_tail_dout),
        .rd_en        (if_read),
        .rd_data      (if_dout),
        .empty_n      (if_empty_n),
        .overflow_err (overflow_err)
    );

endmodule

// File: tb/tb_rs_pipeline_credit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rs_pipeline_credit_ctrl
// Bench for rs_pipeline_credit_ctrl with DATA_WIDTH=32, PIPE_LEVEL=4, DEPTH=8.
// The bench plays the external relay-station pipeline (a PIPE_LEVEL-deep shift
// of the head outputs) and can bypass it to inject tail words directly.
// A queue-based reference model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_rs_pipeline_credit_ctrl;

    localparam int DW = 32;
    localparam int PL = 4;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] if_din;
    logic          if_write;
    logic          if_full_n;
    logic [DW-1:0] pp_head_din;
    logic          pp_head_valid;
    logic [DW-1:0] pp_tail_dout;
    logic          pp_tail_valid;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic          if_read;
    logic          idle;
    logic          overflow_err;

    rs_pipeline_credit_ctrl #(
        .DATA_WIDTH (DW),
        .PIPE_LEVEL (PL),
        .DEPTH      (DP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_din        (if_din),
        .if_write      (if_write),
        .if_full_n     (if_full_n),
        .pp_head_din   (pp_head_din),
        .pp_head_valid (pp_head_valid),
        .pp_tail_dout  (pp_tail_dout),
        .pp_tail_valid (pp_tail_valid),
        .if_dout       (if_dout),
        .if_empty_n    (if_empty_n),
        .if_read       (if_read),
        .idle          (idle),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_credits = DP;
    logic [DW-1:0] m_q[$];
    logic          m_ovf    = 1'b0;
    logic          m_head_v = 1'b0;
    logic [DW-1:0] m_head_d = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_credits = DP;
            m_q.delete();
            m_ovf     = 1'b0;
            m_head_v  = 1'b0;
            m_head_d  = '0;
        end else begin
            automatic bit acc_w = if_write && (m_credits != 0);
            automatic bit acc_r = if_read && (m_q.size() != 0);
            automatic int held  = m_q.size();
            if (acc_r) void'(m_q.pop_front());
            if (pp_tail_valid) begin
                if (held == DP) m_ovf = 1'b1;
                else            m_q.push_back(pp_tail_dout);
            end
            m_credits = m_credits + int'(acc_r) - int'(acc_w);
            m_head_v  = acc_w;
            m_head_d  = if_din;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_full_n",     DW'(if_full_n),     DW'(m_credits != 0));
            check("cmp_idle",       DW'(idle),          DW'(m_credits == DP));
            check("cmp_empty_n",    DW'(if_empty_n),    DW'(m_q.size() != 0));
            check("cmp_overflow",   DW'(overflow_err),  DW'(m_ovf));
            check("cmp_head_valid", DW'(pp_head_valid), DW'(m_head_v));
            check("cmp_head_din",   pp_head_din,        m_head_d);
            if (m_q.size() != 0) check("cmp_dout", if_dout, m_q[0]);
        end
    end

    // ---------------- external pipeline / stimulus ----------------
    logic          pipe_v [PL];
    logic [DW-1:0] pipe_d [PL];
    bit            inject_mode = 1'b0;
    logic          inj_v = 1'b0;
    logic [DW-1:0] inj_d = '0;
    int            tail_seen = 0;

    task automatic clear_pipe();
        for (int i = 0; i < PL; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        pp_tail_valid = 1'b0;
        pp_tail_dout  = '0;
    endtask

    // Drive one cycle at the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        logic          tv;
        logic [DW-1:0] td;
        @(negedge clk);
        tv = pipe_v[PL-1];
        td = pipe_d[PL-1];
        for (int i = PL - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = inject_mode ? 1'b0 : pp_head_valid;
        pipe_d[0] = pp_head_din;
        if (inject_mode) begin
            pp_tail_valid = inj_v;
            pp_tail_dout  = inj_d;
        end else begin
            pp_tail_valid = tv;
            pp_tail_dout  = td;
        end
        if (pp_tail_valid) tail_seen++;
        if_write = w;
        if_din   = d;
        if_read  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        automatic int            accepted = 0;
        automatic bit            dropped  = 1'b0;
        automatic logic [DW-1:0] out_q[$];

        reset    = 1'b1;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        clear_pipe();
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset then idle
        check("rst_full_n",   DW'(if_full_n),    DW'(1));
        check("rst_empty_n",  DW'(if_empty_n),   DW'(0));
        check("rst_idle",     DW'(idle),         DW'(1));
        check("rst_overflow", DW'(overflow_err), DW'(0));

        // Burst of 10 writes with a stalled consumer: 8 accepted
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(32'hB000 + i), 1'b0);
            if (pp_head_valid) accepted++;
            if (i == 7) check("burst_full_n_after_8th", DW'(if_full_n), DW'(0));
        end
        check("burst_accepted", DW'(accepted), DW'(8));
        repeat (6) step(1'b0, '0, 1'b0);
        check("burst_tail_words", DW'(tail_seen), DW'(8));
        check("burst_empty_n",    DW'(if_empty_n),   DW'(1));
        check("burst_first_word", if_dout,           DW'(32'hB000));
        check("burst_overflow",   DW'(overflow_err), DW'(0));

        // Credit return from the full state
        step(1'b0, '0, 1'b1);
        check("credit_full_n", DW'(if_full_n), DW'(1));
        step(1'b1, DW'(32'hC0DE), 1'b0);
        check("credit_write_accepted", DW'(pp_head_valid), DW'(1));
        check("credit_full_n_again",   DW'(if_full_n),     DW'(0));
        repeat (16) step(1'b0, '0, 1'b1);
        check("drain_idle",    DW'(idle),       DW'(1));
        check("drain_empty_n", DW'(if_empty_n), DW'(0));

        // Steady state: continuous write and read
        for (int i = 0; i < 24; i++) begin
            if (if_empty_n) out_q.push_back(if_dout);
            step(1'b1, DW'(32'h1000 + i), 1'b1);
            if (!if_full_n) dropped = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            if (if_empty_n) out_q.push_back(if_dout);
            step(1'b0, '0, 1'b1);
        end
        check("steady_full_n_held", DW'(dropped),      DW'(0));
        check("steady_word_count",  DW'(out_q.size()), DW'(24));
        for (int i = 0; i < out_q.size() && i < 24; i++) begin
            check("steady_order", out_q[i], DW'(32'h1000 + i));
        end

        // Overflow: 9 injected tail words, 8 credited writes, no reads
        inject_mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            inj_v = 1'b1;
            inj_d = DW'(32'hA000 + i);
            step(i < 8, DW'(32'hD000 + i), 1'b0);
            if (i == 7) check("ovf_before_9th", DW'(overflow_err), DW'(0));
        end
        inj_v = 1'b0;
        check("ovf_after_9th", DW'(overflow_err), DW'(1));
        check("ovf_full_n",    DW'(if_full_n),    DW'(0));
        for (int i = 0; i < 8; i++) begin
            check("ovf_readback", if_dout, DW'(32'hA000 + i));
            step(1'b0, '0, 1'b1);
        end
        check("ovf_count_was_8", DW'(if_empty_n),   DW'(0));
        check("ovf_idle",        DW'(idle),         DW'(1));
        check("ovf_sticky",      DW'(overflow_err), DW'(1));
        inject_mode = 1'b0;
        step(1'b0, '0, 1'b0);

        // Reset mid-burst with 5 words buffered
        for (int i = 0; i < 5; i++) step(1'b1, DW'(32'hE000 + i), 1'b0);
        repeat (6) step(1'b0, '0, 1'b0);
        check("mid_empty_n_before", DW'(if_empty_n), DW'(1));
        check("mid_idle_before",    DW'(idle),       DW'(0));
        #2 reset = 1'b1;
        #1;
        check("mid_rst_empty_n",  DW'(if_empty_n),    DW'(0));
        check("mid_rst_idle",     DW'(idle),          DW'(1));
        check("mid_rst_full_n",   DW'(if_full_n),     DW'(1));
        check("mid_rst_overflow", DW'(overflow_err),  DW'(0));
        check("mid_rst_head_v",   DW'(pp_head_valid), DW'(0));
        if_write = 1'b0;
        if_read  = 1'b0;
        clear_pipe();
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        if_write = 1'b1;
        if_din   = DW'(32'hF00D);
        @(posedge clk);
        #1;
        check("post_rst_write_v", DW'(pp_head_valid), DW'(1));
        check("post_rst_write_d", pp_head_din,        DW'(32'hF00D));
        repeat (10) step(1'b0, '0, 1'b1);
        check("final_idle",    DW'(idle),       DW'(1));
        check("final_empty_n", DW'(if_empty_n), DW'(0));

        @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
